// File: rtl/jtag_uart_ctrl_pkg.sv
// Shared types and register-field constants for the jtag_uart_ctrl Avalon master.
// Covers the FSM state encoding, register addresses and JTAG UART bit fields.
package jtag_uart_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_DATA = 2'd1,
    RD_CTRL = 2'd2,
    WR_DATA = 2'd3
  } state_e;

  localparam logic DATA_ADDR = 1'b0;
  localparam logic CTRL_ADDR = 1'b1;

  localparam int RVALID_BIT = 15;
  localparam int RAVAIL_MSB = 31;
  localparam int RAVAIL_LSB = 16;
  localparam int WSPACE_MSB = 31;
  localparam int WSPACE_LSB = 16;
  localparam int DATA_LSB   = 0;
  localparam int DATA_MSB   = 7;

endpackage

// File: rtl/jtag_uart_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first active requester at or
// after ptr_i, returning both a one-hot grant and its index.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               valid_o
);

  always_comb begin
    int j;
    j       = 0;
    grant_o = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      j = (int'(ptr_i) + i) % NUM_REQ;
      if (!valid_o && req_i[j]) begin
        valid_o    = 1'b1;
        grant_o[j] = 1'b1;
        idx_o      = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/jtag_uart_ctrl.sv
// Avalon-MM master for the JTAG UART: round-robin TX sharing, control-register
// space tracking and timed RX polling. JTAG_UART_CTRL_TIMEOUT_EN adds a waitrequest watchdog.
module jtag_uart_ctrl #(
  parameter int NUM_REQ        = 2,
  parameter int POLL_CYCLES    = 1024,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                 clk_clk,
  input  logic                 reset_reset,
  input  logic [NUM_REQ-1:0]   tx_req,
  input  logic [NUM_REQ*8-1:0] tx_data,
  output logic [NUM_REQ-1:0]   tx_ack,
  output logic                 rx_valid,
  output logic [7:0]           rx_data,
  output logic                 av_chipselect,
  output logic                 av_address,
  output logic                 av_read_n,
  output logic                 av_write_n,
  output logic [31:0]          av_writedata,
  input  logic [31:0]          av_readdata,
  input  logic                 av_waitrequest
`ifdef JTAG_UART_CTRL_TIMEOUT_EN
  ,output logic                err_timeout
`endif
);
  import jtag_uart_ctrl_pkg::*;

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int PCW   = $clog2(POLL_CYCLES);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   rr_ptr_q, grant_q, arb_idx;
  logic [NUM_REQ-1:0] arb_grant, tx_ack_q;
  logic               arb_valid;
  logic [7:0]         arb_byte, wdata_q, rx_data_q;
  logic [15:0]        wspace_q;
  logic [PCW-1:0]     poll_cnt_q;
  logic               poll_pend_q, poll_expire, rx_valid_q;
  logic               xfer_done, abort, launch_rd, launch_wr;
  logic               unused_rd_bits;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_arb (
    .req_i   (tx_req),
    .ptr_i   (rr_ptr_q),
    .grant_o (arb_grant),
    .idx_o   (arb_idx),
    .valid_o (arb_valid)
  );

  always_comb begin
    arb_byte = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_grant[i]) arb_byte = arb_byte | tx_data[8*i +: 8];
    end
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) state_q <= IDLE;
    else             state_q <= state_d;
  end

  // RX polls outrank TX; an empty wspace turns a TX request into a control read.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (poll_pend_q)                        state_d = RD_DATA;
        else if (arb_valid && wspace_q != '0)   state_d = WR_DATA;
        else if (arb_valid)                     state_d = RD_CTRL;
      end
      default: if (xfer_done || abort) state_d = IDLE;
    endcase
  end

  always_comb begin
    av_chipselect = (state_q != IDLE);
    av_read_n     = !(state_q == RD_DATA || state_q == RD_CTRL);
    av_write_n    = (state_q != WR_DATA);
    av_address    = (state_q == RD_CTRL) ? CTRL_ADDR : DATA_ADDR;
    xfer_done     = (state_q != IDLE) && !av_waitrequest;
    launch_rd     = (state_q == IDLE) && (state_d == RD_DATA);
    launch_wr     = (state_q == IDLE) && (state_d == WR_DATA);
  end

  assign poll_expire = (poll_cnt_q == '0);

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      rr_ptr_q    <= '0;
      grant_q     <= '0;
      wspace_q    <= '0;
      poll_cnt_q  <= PCW'(POLL_CYCLES - 1);
      poll_pend_q <= 1'b0;
      wdata_q     <= '0;
      tx_ack_q    <= '0;
      rx_valid_q  <= 1'b0;
      rx_data_q   <= '0;
    end else begin
      tx_ack_q   <= '0;
      rx_valid_q <= 1'b0;
      poll_cnt_q <= poll_expire ? PCW'(POLL_CYCLES - 1) : poll_cnt_q - PCW'(1);
      if (launch_rd) poll_pend_q <= 1'b0;
      if (launch_wr) begin
        grant_q <= arb_idx;
        wdata_q <= arb_byte;
      end
      if (xfer_done) begin
        case (state_q)
          RD_DATA: begin
            if (av_readdata[RVALID_BIT]) begin
              rx_data_q  <= av_readdata[DATA_MSB:DATA_LSB];
              rx_valid_q <= 1'b1;
            end
            if (av_readdata[RAVAIL_MSB:RAVAIL_LSB] != '0) poll_pend_q <= 1'b1;
          end
          RD_CTRL: wspace_q <= av_readdata[WSPACE_MSB:WSPACE_LSB];
          WR_DATA: begin
            tx_ack_q[grant_q] <= 1'b1;
            wspace_q          <= wspace_q - 16'd1;
            rr_ptr_q          <= (grant_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_q + IDX_W'(1);
          end
          default: ;
        endcase
      end
      if (abort) wspace_q <= '0;
      // A timer expiry always leaves a request pending, even during a launch.
      if (poll_expire) poll_pend_q <= 1'b1;
    end
  end

`ifdef JTAG_UART_CTRL_TIMEOUT_EN
  localparam int TCW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TCW-1:0] to_cnt_q;
  logic           err_q;

  assign abort = (state_q != IDLE) && av_waitrequest && (to_cnt_q == TCW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      to_cnt_q <= '0;
      err_q    <= 1'b0;
    end else if (state_q == IDLE || !av_waitrequest || abort) begin
      to_cnt_q <= '0;
      if (abort) err_q <= 1'b1;
    end else begin
      to_cnt_q <= to_cnt_q + TCW'(1);
    end
  end

  assign err_timeout    = err_q;
  assign unused_rd_bits = ^av_readdata[14:8];
`else
  assign abort          = 1'b0;
  assign unused_rd_bits = ^{av_readdata[14:8], (TIMEOUT_CYCLES != 0)};
`endif

  assign tx_ack       = tx_ack_q;
  assign rx_valid     = rx_valid_q;
  assign rx_data      = rx_data_q;
  assign av_writedata = {24'b0, wdata_q};

endmodule

// File: tb/tb_jtag_uart_ctrl.sv
// Bench for jtag_uart_ctrl: Avalon slave model, per-requester drivers and a
// scoreboard of expected bus transactions, acks and received bytes.
module tb_jtag_uart_ctrl;

  localparam int NUM_REQ = 2;
  localparam int POLL    = 64;
  localparam int TMO     = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset_reset;
  logic rst_seen = 1'b0;
  always @(posedge clk) rst_seen <= reset_reset;

  // ---------------- DUT ----------------
  logic        req0 = 1'b0, req1 = 1'b0;
  logic [7:0]  d0 = '0, d1 = '0;
  logic [NUM_REQ-1:0]   tx_req;
  logic [NUM_REQ*8-1:0] tx_data;
  logic [NUM_REQ-1:0]   tx_ack;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        av_chipselect, av_address, av_read_n, av_write_n;
  logic [31:0] av_writedata;
  logic [31:0] av_readdata = '0;
  logic        av_waitrequest = 1'b0;
`ifdef JTAG_UART_CTRL_TIMEOUT_EN
  logic        err_timeout;
`endif

  assign tx_req  = {req1, req0};
  assign tx_data = {d1, d0};

  jtag_uart_ctrl #(.NUM_REQ(NUM_REQ), .POLL_CYCLES(POLL), .TIMEOUT_CYCLES(TMO)) dut (
    .clk_clk        (clk),
    .reset_reset    (reset_reset),
    .tx_req         (tx_req),
    .tx_data        (tx_data),
    .tx_ack         (tx_ack),
    .rx_valid       (rx_valid),
    .rx_data        (rx_data),
    .av_chipselect  (av_chipselect),
    .av_address     (av_address),
    .av_read_n      (av_read_n),
    .av_write_n     (av_write_n),
    .av_writedata   (av_writedata),
    .av_readdata    (av_readdata),
    .av_waitrequest (av_waitrequest)
`ifdef JTAG_UART_CTRL_TIMEOUT_EN
    ,.err_timeout   (err_timeout)
`endif
  );

  // ---------------- scoreboard state ----------------
  logic [8:0]  exp_txn_q[$];   // {is_write, byte}; control reads are 9'h000
  logic [10:0] exp_ack_q[$];   // {requester index, byte}
  logic [7:0]  exp_rx_q[$];
  logic [31:0] ctrl_resp_q[$];
  logic [31:0] data_resp_q[$];
  int          dstart_q[$];
  logic [7:0]  q0[$], q1[$];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int stall_wr = 0;
  int last_wr_len = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- requester drivers ----------------
  always @(negedge clk) begin
    if (tx_ack[0] && q0.size() > 0) void'(q0.pop_front());
    if (q0.size() > 0) begin req0 = 1'b1; d0 = q0[0]; end
    else req0 = 1'b0;
  end

  always @(negedge clk) begin
    if (tx_ack[1] && q1.size() > 0) void'(q1.pop_front());
    if (q1.size() > 0) begin req1 = 1'b1; d1 = q1[0]; end
    else req1 = 1'b0;
  end

  // ---------------- Avalon slave model + monitor ----------------
  logic        in_txn = 1'b0;
  logic        snap_addr, snap_rd_n, snap_wr_n, stable_ok;
  logic [31:0] snap_wd;
  logic [7:0]  last_wbyte = '0;
  int          txn_len = 0;
  int          wait_left = 0;

  always @(negedge clk) begin
    logic [8:0]  e9;
    logic [10:0] e11;
    logic [7:0]  e8;
    int          idx;
    cyc++;
    // completion happened at the posedge just before this negedge
    if (in_txn && !av_waitrequest && !rst_seen) begin
      in_txn = 1'b0;
      check("bus_stable", {31'b0, stable_ok}, 32'd1);
      if (!snap_wr_n && snap_rd_n) begin
        check("wr_expected", {31'b0, exp_txn_q.size() != 0}, 32'd1);
        if (exp_txn_q.size() != 0) begin
          e9 = exp_txn_q.pop_front();
          check("txn_order", {23'b0, 1'b1, snap_wd[7:0]}, {23'b0, e9});
        end
        check("wdata_hi", {8'b0, snap_wd[31:8]}, 32'd0);
        check("wr_addr", {31'b0, snap_addr}, 32'd0);
        last_wbyte  = snap_wd[7:0];
        last_wr_len = txn_len;
      end else if (!snap_rd_n && snap_wr_n && snap_addr) begin
        check("ctrl_expected", {31'b0, exp_txn_q.size() != 0}, 32'd1);
        if (exp_txn_q.size() != 0) begin
          e9 = exp_txn_q.pop_front();
          check("txn_order", 32'd0, {23'b0, e9});
        end
      end else if (!(!snap_rd_n && snap_wr_n)) begin
        check("strobe_combo", {30'b0, snap_rd_n, snap_wr_n}, 32'd1);
      end
    end else if (in_txn && !av_chipselect) begin
      in_txn = 1'b0;
    end

    if (in_txn) begin
      txn_len++;
      if (av_chipselect !== 1'b1 || av_read_n !== snap_rd_n || av_write_n !== snap_wr_n ||
          av_address !== snap_addr || av_writedata !== snap_wd)
        stable_ok = 1'b0;
    end else if (av_chipselect) begin
      in_txn    = 1'b1;
      snap_addr = av_address;
      snap_rd_n = av_read_n;
      snap_wr_n = av_write_n;
      snap_wd   = av_writedata;
      stable_ok = 1'b1;
      txn_len   = 1;
      if (!av_read_n && av_address)
        av_readdata = (ctrl_resp_q.size() != 0) ? ctrl_resp_q.pop_front() : 32'h0040_0000;
      else if (!av_read_n) begin
        av_readdata = (data_resp_q.size() != 0) ? data_resp_q.pop_front() : 32'h0;
        dstart_q.push_back(cyc);
      end else
        av_readdata = 32'h0;
      wait_left = (!av_write_n) ? stall_wr : 0;
      if (!av_write_n) stall_wr = 0;
    end

    if (in_txn) begin
      av_waitrequest = (wait_left > 0);
      if (wait_left > 0) wait_left--;
    end else begin
      av_waitrequest = 1'b0;
    end

    if (tx_ack != '0) begin
      check("ack_onehot", {31'b0, $onehot(tx_ack)}, 32'd1);
      idx = tx_ack[1] ? 1 : 0;
      check("ack_expected", {31'b0, exp_ack_q.size() != 0}, 32'd1);
      if (exp_ack_q.size() != 0) begin
        e11 = exp_ack_q.pop_front();
        check("ack", {21'b0, 3'(idx), last_wbyte}, {21'b0, e11});
      end
    end

    if (rx_valid) begin
      check("rx_expected", {31'b0, exp_rx_q.size() != 0}, 32'd1);
      if (exp_rx_q.size() != 0) begin
        e8 = exp_rx_q.pop_front();
        check("rx_data", {24'b0, rx_data}, {24'b0, e8});
      end
    end
  end

  // ---------------- helper tasks ----------------
  task automatic do_reset();
    @(negedge clk);
    reset_reset = 1'b1;
    repeat (2) @(negedge clk);
    reset_reset = 1'b0;
    dstart_q.delete();
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((exp_txn_q.size() != 0 || exp_ack_q.size() != 0 || exp_rx_q.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("drain_in_time", {31'b0, n < budget}, 32'd1);
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_write(input int budget);
    int n = 0;
    while (av_write_n !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("write_seen", {31'b0, n < budget}, 32'd1);
  endtask

  task automatic push_wr(input logic [7:0] b, input logic [2:0] idx);
    exp_txn_q.push_back({1'b1, b});
    exp_ack_q.push_back({idx, b});
  endtask

  // ---------------- directed tests ----------------
  initial begin
    reset_reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_cs",     {31'b0, av_chipselect}, 32'd0);
    check("rst_read_n", {31'b0, av_read_n},     32'd1);
    check("rst_write_n",{31'b0, av_write_n},    32'd1);
    check("rst_addr",   {31'b0, av_address},    32'd0);
    check("rst_wdata",  av_writedata,           32'd0);
    check("rst_ack",    {30'b0, tx_ack},        32'd0);
    check("rst_rxv",    {31'b0, rx_valid},      32'd0);
    check("rst_rxd",    {24'b0, rx_data},       32'd0);
`ifdef JTAG_UART_CTRL_TIMEOUT_EN
    check("rst_err",    {31'b0, err_timeout},   32'd0);
`endif
    reset_reset = 1'b0;

    // single TX: ctrl read (64 free) then two writes with no second ctrl read
    ctrl_resp_q.push_back(32'h0040_0000);
    exp_txn_q.push_back(9'h000);
    push_wr(8'h41, 3'd0);
    push_wr(8'h42, 3'd0);
    q0.push_back(8'h41);
    q0.push_back(8'h42);
    wait_drain(2000);

    // round-robin: both requesters held, grants alternate 0,1,0,1,...
    do_reset();
    exp_txn_q.push_back(9'h000);
    for (int i = 0; i < 4; i++) begin
      push_wr(8'h10 + 8'(i), 3'd0);
      push_wr(8'h20 + 8'(i), 3'd1);
      q0.push_back(8'h10 + 8'(i));
      q1.push_back(8'h20 + 8'(i));
    end
    wait_drain(2000);

    // full FIFO: three WSPACE=0 reads, then WSPACE=2 allows exactly two writes
    do_reset();
    ctrl_resp_q.push_back(32'h0000_0000);
    ctrl_resp_q.push_back(32'h0000_0000);
    ctrl_resp_q.push_back(32'h0000_0000);
    ctrl_resp_q.push_back(32'h0002_0000);
    repeat (4) exp_txn_q.push_back(9'h000);
    push_wr(8'h31, 3'd0);
    push_wr(8'h32, 3'd0);
    exp_txn_q.push_back(9'h000);
    push_wr(8'h33, 3'd0);
    q0.push_back(8'h31);
    q0.push_back(8'h32);
    q0.push_back(8'h33);
    wait_drain(2000);

    // RX drain: back-to-back reads while RAVAIL!=0, then wait for the timer
    do_reset();
    data_resp_q.push_back(32'h0002_8055);
    data_resp_q.push_back(32'h0001_8056);
    data_resp_q.push_back(32'h0000_8057);
    exp_rx_q.push_back(8'h55);
    exp_rx_q.push_back(8'h56);
    exp_rx_q.push_back(8'h57);
    begin
      int n = 0;
      while (dstart_q.size() < 4 && n < 400) begin
        @(negedge clk);
        n++;
      end
      check("rx_reads_seen", {31'b0, dstart_q.size() >= 4}, 32'd1);
      if (dstart_q.size() >= 4) begin
        check("rx_gap1",  32'(dstart_q[1] - dstart_q[0]), 32'd2);
        check("rx_gap2",  32'(dstart_q[2] - dstart_q[1]), 32'd2);
        check("rx_period",32'(dstart_q[3] - dstart_q[0]), 32'(POLL));
      end
    end
    wait_drain(200);

    // 5-cycle stall on a write; requester drops tx_req after grant
    do_reset();
    stall_wr = 5;
    exp_txn_q.push_back(9'h000);
    push_wr(8'h5A, 3'd0);
    q0.push_back(8'h5A);
    wait_write(500);
    q0.delete();
    wait_drain(500);
    check("stall_len", 32'(last_wr_len), 32'd6);

    // reset during a stalled write: no ack, first transaction afterwards is a ctrl read
    do_reset();
    stall_wr = 1000;
    exp_txn_q.push_back(9'h000);
    q0.push_back(8'h66);
    wait_write(500);
    repeat (3) @(negedge clk);
    reset_reset = 1'b1;
    @(negedge clk);
    check("midrst_cs",      {31'b0, av_chipselect}, 32'd0);
    check("midrst_write_n", {31'b0, av_write_n},    32'd1);
    check("midrst_ack",     {30'b0, tx_ack},        32'd0);
    @(negedge clk);
    reset_reset = 1'b0;
    exp_txn_q.push_back(9'h000);
    push_wr(8'h66, 3'd0);
    wait_drain(1000);

`ifdef JTAG_UART_CTRL_TIMEOUT_EN
    // 20-cycle stall with a 16-cycle watchdog: abort, no ack, then ctrl read and retry
    do_reset();
    stall_wr = 20;
    exp_txn_q.push_back(9'h000);
    exp_txn_q.push_back(9'h000);
    push_wr(8'h77, 3'd0);
    q0.push_back(8'h77);
    wait_drain(1000);
    check("err_timeout", {31'b0, err_timeout}, 32'd1);
`endif

    check("txn_left", 32'(exp_txn_q.size()), 32'd0);
    check("ack_left", 32'(exp_ack_q.size()), 32'd0);
    check("rx_left",  32'(exp_rx_q.size()),  32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
